// File: rtl/noc_bus_arbiter.sv
// N-to-1 NoC request bus concentrator: per-channel FIFOs drained by a
// round-robin arbiter onto one registered, source-tagged output bus.
module noc_bus_arbiter #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_BYTES = 32,
    parameter int BP_W       = 6,
    localparam int SRC_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int DW        = DATA_BYTES * 8
) (
    input  logic                     fclk,
    input  logic                     rst,
    input  logic [CHANNELS*DW-1:0]   inp_dat,
    input  logic [CHANNELS*BP_W-1:0] inp_bp,
    input  logic [CHANNELS-1:0]      inp_bo,
    output logic [CHANNELS-1:0]      inp_full,
    output logic [CHANNELS-1:0]      ovf,
    input  logic                     ovf_clr,
    output logic [DW-1:0]            oup_dat,
    output logic [BP_W-1:0]          oup_bp,
    output logic                     oup_bo,
    output logic [SRC_W-1:0]         oup_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + BP_W;

    logic [EW-1:0]       mem_q [CHANNELS][DEPTH];
    logic [AW-1:0]       wr_q  [CHANNELS];
    logic [AW-1:0]       rd_q  [CHANNELS];
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [SRC_W-1:0]    last_q;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] full, push, pop, accept, drop;

    logic                gnt_vld;
    logic [SRC_W-1:0]    gnt_idx;
    logic [SRC_W-1:0]    scan_idx;
    logic [EW-1:0]       head;

    logic [DW-1:0]       dat_q;
    logic [BP_W-1:0]     bp_q;
    logic                bo_q;
    logic [SRC_W-1:0]    src_q;

    // Round-robin scan starting just after the last granted channel;
    // only occupancy before this edge makes a channel a candidate.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            scan_idx = SRC_W'((int'(last_q) + k) % CHANNELS);
            if (!gnt_vld && cnt_q[scan_idx] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Per-channel push/pop decisions; a full FIFO still accepts when popped.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            full[i]   = (cnt_q[i] == CW'(DEPTH));
            push[i]   = inp_bo[i] && (inp_bp[i*BP_W +: BP_W] != '0);
            pop[i]    = gnt_vld && (gnt_idx == SRC_W'(i));
            accept[i] = push[i] && (!full[i] || pop[i]);
            drop[i]   = push[i] && !accept[i];
            cnt_d[i]  = cnt_q[i] + CW'(accept[i]) - CW'(pop[i]);
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | drop;
    end

    assign head = mem_q[gnt_idx][rd_q[gnt_idx]];

    // FIFO storage; stale entries are unreachable once counts are cleared.
    always_ff @(posedge fclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (accept[i]) begin
                mem_q[i][wr_q[i]] <= {inp_bp[i*BP_W +: BP_W],
                                      inp_dat[i*DW +: DW]};
            end
        end
    end

    // Pointers, occupancy, arbitration history and sticky overflow flags.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            last_q <= SRC_W'(CHANNELS - 1);
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept[i]) wr_q[i] <= wr_q[i] + AW'(1);
                if (pop[i])    rd_q[i] <= rd_q[i] + AW'(1);
                cnt_q[i] <= cnt_d[i];
            end
            if (gnt_vld) last_q <= gnt_idx;
            ovf_q <= ovf_d;
        end
    end

    // Output register: winner's head beat, payload held when idle.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            bp_q  <= '0;
            bo_q  <= 1'b0;
            src_q <= '0;
        end else begin
            bo_q <= gnt_vld;
            if (gnt_vld) begin
                bp_q  <= head[EW-1:DW];
                dat_q <= head[DW-1:0];
                src_q <= gnt_idx;
            end
        end
    end

    assign inp_full = full;
    assign ovf      = ovf_q;
    assign oup_dat  = dat_q;
    assign oup_bp   = bp_q;
    assign oup_bo   = bo_q;
    assign oup_src  = src_q;

endmodule

// File: tb/tb_noc_bus_arbiter.sv
// Scoreboard bench for noc_bus_arbiter: a queue-based reference model
// predicts every merged beat; a negedge monitor checks the DUT output.
module tb_noc_bus_arbiter;

    localparam int C   = 4;
    localparam int D   = 4;
    localparam int DB  = 32;
    localparam int BPW = 6;
    localparam int SW  = 2;
    localparam int DW  = DB * 8;

    typedef struct packed {
        logic [SW-1:0]  src;
        logic [BPW-1:0] bp;
        logic [DW-1:0]  dat;
    } beat_t;

    logic              fclk;
    logic              rst;
    logic [C*DW-1:0]   inp_dat;
    logic [C*BPW-1:0]  inp_bp;
    logic [C-1:0]      inp_bo;
    logic [C-1:0]      inp_full;
    logic [C-1:0]      ovf;
    logic              ovf_clr;
    logic [DW-1:0]     oup_dat;
    logic [BPW-1:0]    oup_bp;
    logic              oup_bo;
    logic [SW-1:0]     oup_src;

    int tests = 0;
    int fails = 0;

    beat_t      mq [C][$];
    beat_t      sb [$];
    int         m_last = C - 1;
    logic       m_bo = 1'b0;
    logic [C-1:0] m_ovf = '0;

    noc_bus_arbiter #(
        .CHANNELS(C), .DEPTH(D), .DATA_BYTES(DB), .BP_W(BPW)
    ) dut (
        .fclk(fclk), .rst(rst),
        .inp_dat(inp_dat), .inp_bp(inp_bp), .inp_bo(inp_bo),
        .inp_full(inp_full), .ovf(ovf), .ovf_clr(ovf_clr),
        .oup_dat(oup_dat), .oup_bp(oup_bp), .oup_bo(oup_bo),
        .oup_src(oup_src)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [DW-1:0] msk(logic [DW-1:0] d,
                                          logic [BPW-1:0] bp);
        logic [DW-1:0] r;
        r = d;
        for (int b = 0; b < DB; b++)
            if (b >= int'(bp)) r[b*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [DW-1:0] rdat();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: one arbitration + push round per clock edge.
    task automatic model_step();
        int    win;
        int    idx;
        beat_t b;
        if (rst) begin
            for (int i = 0; i < C; i++) mq[i].delete();
            sb.delete();
            m_last = C - 1;
            m_bo   = 1'b0;
            m_ovf  = '0;
            return;
        end
        win = -1;
        for (int k = 1; k <= C; k++) begin
            idx = (m_last + k) % C;
            if (win < 0 && mq[idx].size() > 0) win = idx;
        end
        if (win >= 0) begin
            b = mq[win].pop_front();
            sb.push_back(b);
            m_last = win;
            m_bo   = 1'b1;
        end else begin
            m_bo = 1'b0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < C; i++) begin
            if (inp_bo[i] && inp_bp[i*BPW +: BPW] != '0) begin
                if (mq[i].size() < D) begin
                    b.src = SW'(i);
                    b.bp  = inp_bp[i*BPW +: BPW];
                    b.dat = inp_dat[i*DW +: DW];
                    mq[i].push_back(b);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge fclk or posedge rst);
        model_step();
    end

    // Monitor: compare whatever the DUT presents against the model.
    initial forever begin
        beat_t        e;
        logic [C-1:0] ef;
        @(negedge fclk);
        chk("oup_bo", DW'(oup_bo), DW'(m_bo));
        if (oup_bo) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", DW'(1), DW'(0));
            end else begin
                e = sb.pop_front();
                chk("oup_src", DW'(oup_src), DW'(e.src));
                chk("oup_bp", DW'(oup_bp), DW'(e.bp));
                chk("oup_dat", msk(oup_dat, oup_bp), msk(e.dat, e.bp));
            end
        end
        for (int i = 0; i < C; i++) ef[i] = (mq[i].size() == D);
        chk("inp_full", DW'(inp_full), DW'(ef));
        chk("ovf", DW'(ovf), DW'(m_ovf));
    end

    task automatic idle();
        inp_bo  = '0;
        inp_bp  = '0;
        inp_dat = '0;
        ovf_clr = 1'b0;
    endtask

    task automatic drive(int ch, logic [BPW-1:0] bp, logic [DW-1:0] d);
        inp_bo[ch]            = 1'b1;
        inp_bp[ch*BPW +: BPW] = bp;
        inp_dat[ch*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge fclk);
        @(negedge fclk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge fclk);
        #1 rst = 1'b0;
    endtask

    function automatic int pending();
        int n;
        n = sb.size();
        for (int i = 0; i < C; i++) n += mq[i].size();
        return n;
    endfunction

    logic [C-1:0] saw_full;

    initial begin
        do_reset();
        chk("rst_bo", DW'(oup_bo), DW'(0));
        chk("rst_dat", oup_dat, DW'(0));
        chk("rst_bp", DW'(oup_bp), DW'(0));
        chk("rst_src", DW'(oup_src), DW'(0));
        chk("rst_ovf", DW'(ovf), DW'(0));
        chk("rst_full", DW'(inp_full), DW'(0));

        // single beat on ch2
        drive(2, 6'd32, DW'(8'hA5));
        tick();
        idle();
        tick();
        chk("single_bo", DW'(oup_bo), DW'(1));
        chk("single_src", DW'(oup_src), DW'(2));
        chk("single_bp", DW'(oup_bp), DW'(32));
        chk("single_b0", DW'(oup_dat[7:0]), DW'(8'hA5));
        tick();
        chk("single_end", DW'(oup_bo), DW'(0));

        // contention from a fresh arbiter
        do_reset();
        for (int ch = 0; ch < C; ch++) drive(ch, 6'd32, DW'(ch * 16));
        tick();
        idle();
        for (int i = 0; i < C; i++) begin
            tick();
            chk("cont_src", DW'(oup_src), DW'(i));
            chk("cont_b0", DW'(oup_dat[7:0]), DW'(i * 16));
        end
        tick();
        chk("cont_end", DW'(oup_bo), DW'(0));

        // fairness between ch1 and ch3
        do_reset();
        for (int n = 0; n < 10; n++) begin
            drive(1, 6'd32, DW'(16 + n));
            drive(3, 6'd32, DW'(48 + n));
            tick();
            idle();
        end
        repeat (20) tick();
        chk("fair_drained", DW'(pending()), DW'(0));
        ovf_clr = 1'b1;
        tick();
        idle();

        // overflow on all channels
        do_reset();
        saw_full = '0;
        for (int n = 0; n < 8; n++) begin
            for (int ch = 0; ch < C; ch++)
                drive(ch, 6'd32, DW'(ch * 16 + n));
            tick();
            saw_full |= inp_full;
            idle();
        end
        chk("ovf_all", DW'(ovf), DW'(4'hF));
        chk("saw_full", DW'(saw_full), DW'(4'hF));
        repeat (30) tick();
        chk("ovf_drained", DW'(pending()), DW'(0));

        // ovf_clr colliding with a new drop on ch0
        do_reset();
        for (int n = 0; n < 5; n++) begin
            for (int ch = 0; ch < C; ch++) drive(ch, 6'd8, rdat());
            tick();
            idle();
        end
        drive(0, 6'd8, rdat());
        drive(1, 6'd8, rdat());
        tick();
        idle();
        chk("clr_pre", DW'(ovf), DW'(4'b0010));
        drive(0, 6'd8, rdat());
        ovf_clr = 1'b1;
        tick();
        idle();
        chk("clr_coll", DW'(ovf), DW'(4'b0001));

        // reset with 3 beats queued per channel
        repeat (3) tick();
        chk("pre_rst_bo", DW'(oup_bo), DW'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bo", DW'(oup_bo), DW'(0));
        chk("rst_async_dat", oup_dat, DW'(0));
        @(negedge fclk);
        #1 rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("post_rst_idle", DW'(oup_bo), DW'(0));
        end
        for (int ch = 0; ch < C; ch++) drive(ch, 6'd4, rdat());
        tick();
        idle();
        tick();
        chk("post_rst_first", DW'(oup_src), DW'(0));
        repeat (5) tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int ch = 0; ch < C; ch++)
                if ($urandom_range(0, 99) < 40)
                    drive(ch, BPW'($urandom_range(0, DB)), rdat());
            ovf_clr = ($urandom_range(0, 19) == 0);
            tick();
            idle();
        end
        repeat (30) tick();
        chk("rand_drained", DW'(pending()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
